input_debouncer: RTL and testbench

Synchronises and debounces a raw asynchronous input (push-button, switch or external status pin) into a clean, glitch-free level in the `clk` domain. It sits directly upstream of the edge-detection stage: its `signal_clean` output drives that stage's `signal_in`. A level change propagates only after it has been stable for a programmable number of cycles. Rejected glitches are counted for board bring-up diagnostics.

---
 rtl/input_debouncer.sv | 127 ++++++++++++
 tb/tb_input_debouncer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
`timescale 1ns/1ps
// input_debouncer
// Synchronises a raw asynchronous input into the clk domain. A level change
// reaches signal_clean only after the synchronised level has differed from
// signal_clean for DEBOUNCE_CYCLES consecutive samples. Shorter excursions
// are dropped and counted in a saturating 8-bit diagnostic counter.
module input_debouncer #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       reset_qual_n,
  input  logic       signal_raw,
  input  logic       glitch_clr,
  output logic       signal_clean,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  localparam int                   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{RESET_LEVEL}};

  // Two legal codes; the other two encodings are recovered to STABLE.
  typedef enum logic [1:0] {
    ST_STABLE  = 2'b01,
    ST_QUALIFY = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   busy_q, busy_d;
  logic [7:0]             gcnt_q, gcnt_d;
  logic                   glitch_evt;

  // Saturating increment: the diagnostic count sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end
    return v + 8'd1;
  endfunction

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: plain shift register, nothing between stages.
  always_ff @(posedge clk or negedge reset_qual_n) begin
    if (!reset_qual_n) begin
      sync_q <= SYNC_RST;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_raw};
    end
  end

  // Next-state logic: qualify a mismatch for DEBOUNCE_CYCLES samples or flag a glitch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clean_d    = clean_q;
    glitch_evt = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync_out != clean_q) begin
          state_d = ST_QUALIFY;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_QUALIFY: begin
        if (sync_out == clean_q) begin
          state_d    = ST_STABLE;
          cnt_d      = '0;
          glitch_evt = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          clean_d = sync_out;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_QUALIFY);
  end

  // Glitch counter next value: a clear in the same cycle as a rejection wins.
  always_comb begin
    gcnt_d = gcnt_q;
    if (glitch_clr) begin
      gcnt_d = '0;
    end else if (glitch_evt) begin
      gcnt_d = sat_inc8(gcnt_q);
    end
  end

  // State, counter and output registers; reset aborts any qualification at once.
  always_ff @(posedge clk or negedge reset_qual_n) begin
    if (!reset_qual_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      clean_q <= RESET_LEVEL;
      busy_q  <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      busy_q  <= busy_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign signal_clean = clean_q;
  assign busy         = busy_q;
  assign glitch_cnt   = gcnt_q;

endmodule

// File: tb/tb_input_debouncer.sv
`timescale 1ns/1ps
// Testbench for input_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0).
// Explicit vector table for the first scenarios, a run-length reference model
// feeding a scoreboard queue every cycle, and hand-written corner sequences.
module tb_input_debouncer;

  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic       clk;
  logic       reset_qual_n;
  logic       signal_raw;
  logic       glitch_clr;
  logic       signal_clean;
  logic       busy;
  logic [7:0] glitch_cnt;

  int n_checks = 0;
  int n_err    = 0;

  input_debouncer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .clk         (clk),
    .reset_qual_n(reset_qual_n),
    .signal_raw  (signal_raw),
    .glitch_clr  (glitch_clr),
    .signal_clean(signal_clean),
    .busy        (busy),
    .glitch_cnt  (glitch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       raw;
    logic       clr;
    logic       clean;
    logic       busy;
    logic [7:0] gcnt;
  } vec_t;

  typedef struct packed {
    logic       clean;
    logic       busy;
    logic [7:0] gcnt;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  // Reference model state: run length of consecutive mismatching samples.
  logic [SYNC-1:0] m_sync;
  logic            m_clean;
  int              m_run;
  logic            m_busy;
  logic [7:0]      m_gcnt;

  function automatic vec_t mk(input logic raw, input logic clr, input logic c,
                              input logic b, input logic [7:0] g);
    vec_t v;
    v.raw = raw; v.clr = clr; v.clean = c; v.busy = b; v.gcnt = g;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync  = '0;
    m_clean = 1'b0;
    m_run   = 0;
    m_busy  = 1'b0;
    m_gcnt  = 8'd0;
  endtask

  // One clock edge of the reference: a change is accepted on the DC-th
  // consecutive mismatching sample; a match after a partial run is a glitch.
  task automatic model_edge(input logic raw, input logic clr);
    logic so;
    logic glitch;
    so     = m_sync[SYNC-1];
    glitch = 1'b0;
    if (so != m_clean) begin
      m_run = m_run + 1;
      if (m_run == DC) begin
        m_clean = so;
        m_run   = 0;
      end
    end else begin
      if (m_run != 0) glitch = 1'b1;
      m_run = 0;
    end
    m_busy = (m_run != 0);
    if (clr) m_gcnt = 8'd0;
    else if (glitch && m_gcnt != 8'hFF) m_gcnt = m_gcnt + 8'd1;
    m_sync = {m_sync[SYNC-2:0], raw};
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, check after the edge.
  task automatic step(input logic raw, input logic clr);
    exp_t e;
    signal_raw = raw;
    glitch_clr = clr;
    model_edge(raw, clr);
    e.clean = m_clean;
    e.busy  = m_busy;
    e.gcnt  = m_gcnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk1("sb_clean", signal_clean, e.clean);
    chk1("sb_busy", busy, e.busy);
    chk8("sb_gcnt", glitch_cnt, e.gcnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_qual_n = 1'b0;
    signal_raw   = 1'b1;
    glitch_clr   = 1'b0;
    model_reset();

    // Clean rise (edges 1-7), fall back (8-14), 3-cycle glitch (15-21), 4-cycle pulse (22-32)
    vecs.push_back(mk(1, 0, 0, 0, 0)); vecs.push_back(mk(1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0)); vecs.push_back(mk(1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0)); vecs.push_back(mk(1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0)); vecs.push_back(mk(0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0)); vecs.push_back(mk(0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0)); vecs.push_back(mk(0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0)); vecs.push_back(mk(0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0)); vecs.push_back(mk(1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0)); vecs.push_back(mk(0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0)); vecs.push_back(mk(0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1)); vecs.push_back(mk(1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1)); vecs.push_back(mk(1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1)); vecs.push_back(mk(0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1)); vecs.push_back(mk(0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1)); vecs.push_back(mk(0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1));

    // Reset held with signal_raw high
    repeat (4) begin
      @(posedge clk);
      #1;
      chk1("rst_clean", signal_clean, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk8("rst_gcnt", glitch_cnt, 8'd0);
    end
    reset_qual_n = 1'b1;
    model_reset();

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].raw, vecs[i].clr);
      chk1($sformatf("tbl%0d_clean", i + 1), signal_clean, vecs[i].clean);
      chk1($sformatf("tbl%0d_busy", i + 1), busy, vecs[i].busy);
      chk8($sformatf("tbl%0d_gcnt", i + 1), glitch_cnt, vecs[i].gcnt);
    end

    // Saturation: 260 three-cycle glitches on top of the one already counted
    for (int g = 0; g < 260; g++) begin
      step(1, 0); step(1, 0); step(1, 0);
      step(0, 0); step(0, 0); step(0, 0);
    end
    chk8("sat_gcnt", glitch_cnt, 8'd255);
    chk1("sat_clean", signal_clean, 1'b0);

    // Clear coinciding with a glitch rejection: clear wins
    step(1, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    chk8("pre_clr_gcnt", glitch_cnt, 8'd255);
    chk1("pre_clr_busy", busy, 1'b1);
    step(0, 1);
    chk8("clr_vs_glitch_gcnt", glitch_cnt, 8'd0);
    step(0, 0);
    chk8("after_clr_gcnt", glitch_cnt, 8'd0);

    // Async reset in the middle of qualification
    step(1, 0); step(1, 0); step(1, 0); step(1, 0);
    chk1("mid_q_busy", busy, 1'b1);
    reset_qual_n = 1'b0;
    #1;
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_clean", signal_clean, 1'b0);
    chk8("async_rst_gcnt", glitch_cnt, 8'd0);
    @(posedge clk);
    #1;
    reset_qual_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1, 0);
      chk1($sformatf("post_rst_e%0d_clean", k), signal_clean, (k == 6) ? 1'b1 : 1'b0);
    end

    // Settle low, then bounce burst 1,0,1,0,1 followed by a steady high
    for (int k = 0; k < 8; k++) step(0, 0);
    chk1("settle_clean", signal_clean, 1'b0);
    chk8("settle_gcnt", glitch_cnt, 8'd0);
    for (int k = 1; k <= 13; k++) begin
      step((k == 2 || k == 4) ? 1'b0 : 1'b1, 0);
      if (k <= 9) chk1($sformatf("bounce_e%0d_clean", k), signal_clean, 1'b0);
      if (k == 10) chk1("bounce_accept_clean", signal_clean, 1'b1);
    end
    chk1("bounce_final_clean", signal_clean, 1'b1);
    chk8("bounce_final_gcnt", glitch_cnt, 8'd2);
    chk1("bounce_final_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
